fir_sample_uart_tx: RTL and testbench

//  Consumer end of the FIR result interface (48-bit signed value + 1-cycle ready strobe).

---
 rtl/fir_sample_uart_tx_pkg.sv | 29 ++
 rtl/sample_fifo.sv | 47 ++++
 rtl/fir_sample_uart_tx.sv | 141 ++++++++++++++
 tb/tb_fir_sample_uart_tx.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_sample_uart_tx_pkg.sv
// Shared definitions for the FIR-sample UART transmitter: sync byte, frame size, TX states, saturation.
// Latency: none (types, constants and a combinational helper only).
// Backpressure: not applicable.
package fir_sample_uart_tx_pkg;

   localparam logic [7:0] SYNC_BYTE   = 8'hA5;
   localparam int         FRAME_BYTES = 3;

   localparam logic signed [47:0] SAT_MAX = 48'sd32767;
   localparam logic signed [47:0] SAT_MIN = -48'sd32768;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } tx_state_t;

   // Clamp an already-shifted value into the signed 16-bit range.
   function automatic logic [15:0] sat16(input logic signed [47:0] s);
      if (s > SAT_MAX)
         return 16'h7FFF;
      else if (s < SAT_MIN)
         return 16'h8000;
      else
         return s[15:0];
   endfunction

endpackage

// File: rtl/sample_fifo.sv
// Synchronous show-ahead FIFO holding scaled samples between the scaler and the UART FSM.
// Latency: write visible on empty/dout the cycle after push; dout valid in the pop cycle.
// Backpressure: push ignored while full, pop ignored while empty; the caller handles drops.
module sample_fifo #(
   parameter int DW = 16,
   parameter int AW = 3
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          push,
   input  logic          pop,
   input  logic [DW-1:0] din,
   output logic [DW-1:0] dout,
   output logic          full,
   output logic          empty
);

   logic [DW-1:0] mem [2**AW];
   logic [AW:0]   wr_ptr;
   logic [AW:0]   rd_ptr;
   logic          do_push;
   logic          do_pop;

   // Extra pointer bit distinguishes full from empty when the address bits match.
   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign dout    = mem[rd_ptr[AW-1:0]];
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   // Pointer update; push and pop in the same cycle are both honoured.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Storage write; contents need no reset because the pointers define validity.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/fir_sample_uart_tx.sv
// Decimates FIR results, scales/saturates to 16 bits and sends each as an 8N1 frame A5, hi, lo.
// Latency: strobe cycle t -> scale reg t+1, FIFO write t+2, pop t+3, start bit on txd at t+4.
// Backpressure: none upstream; in_ready is accepted every cycle, a kept sample hitting a full FIFO is dropped and sets overflow.
module fir_sample_uart_tx
   import fir_sample_uart_tx_pkg::*;
#(
   parameter int CLKS_PER_BIT = 868,
   parameter int SHIFT        = 16,
   parameter int DECIM        = 64,
   parameter int FIFO_AW      = 3
) (
   input  logic               clk,
   input  logic               reset,
   input  logic signed [47:0] in_val,
   input  logic               in_ready,
   output logic               txd,
   output logic               busy,
   output logic               overflow
);

   localparam int DCW = (DECIM > 1) ? $clog2(DECIM) : 1;
   localparam int BCW = $clog2(CLKS_PER_BIT);

   logic [DCW-1:0]     decim_cnt;
   logic               keep;
   logic signed [47:0] scaled;
   logic [15:0]        sat_q;
   logic               sat_vld;
   logic [15:0]        fifo_dout;
   logic               fifo_full;
   logic               fifo_empty;
   logic               pop;

   tx_state_t          state;
   tx_state_t          state_nxt;
   logic [BCW-1:0]     baud_cnt;
   logic [2:0]         bit_idx;
   logic [1:0]         byte_idx;
   logic [15:0]        hold;
   logic [7:0]         tx_byte;
   logic               txd_nxt;
   logic               bit_done;

   assign keep     = in_ready && (decim_cnt == DCW'(DECIM - 1));
   assign scaled   = in_val >>> SHIFT;
   assign bit_done = (baud_cnt == BCW'(CLKS_PER_BIT - 1));
   assign busy     = (state != ST_IDLE);

   // Decimation counter: every DECIM-th strobe is kept and restarts the count.
   always_ff @(posedge clk) begin
      if (reset)
         decim_cnt <= '0;
      else if (in_ready)
         decim_cnt <= keep ? '0 : decim_cnt + 1'b1;
   end

   // Scale/saturate stage, then push stage; a push that meets a full FIFO latches overflow.
   always_ff @(posedge clk) begin
      if (reset) begin
         sat_q    <= '0;
         sat_vld  <= 1'b0;
         overflow <= 1'b0;
      end else begin
         sat_q   <= sat16(scaled);
         sat_vld <= keep;
         if (sat_vld && fifo_full) overflow <= 1'b1;
      end
   end

   sample_fifo #(
      .DW (16),
      .AW (FIFO_AW)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (sat_vld),
      .pop   (pop),
      .din   (sat_q),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // TX state register.
   always_ff @(posedge clk) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   // TX next-state: three bytes per frame, each START / 8 DATA / STOP.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (!fifo_empty) state_nxt = ST_START;
         ST_START: if (bit_done) state_nxt = ST_DATA;
         ST_DATA:  if (bit_done && (bit_idx == 3'd7)) state_nxt = ST_STOP;
         ST_STOP:  if (bit_done)
                      state_nxt = (byte_idx == 2'(FRAME_BYTES - 1)) ? ST_IDLE : ST_START;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // TX outputs: pop in IDLE, byte selection and the next line level.
   always_comb begin
      pop     = 1'b0;
      txd_nxt = 1'b1;
      case (byte_idx)
         2'd0:    tx_byte = SYNC_BYTE;
         2'd1:    tx_byte = hold[15:8];
         default: tx_byte = hold[7:0];
      endcase
      case (state)
         ST_IDLE:  pop = !fifo_empty;
         ST_START: txd_nxt = 1'b0;
         ST_DATA:  txd_nxt = tx_byte[bit_idx];
         default:  txd_nxt = 1'b1;
      endcase
   end

   // Baud/bit/byte counters, holding register and registered serial line.
   always_ff @(posedge clk) begin
      if (reset) begin
         baud_cnt <= '0;
         bit_idx  <= '0;
         byte_idx <= '0;
         hold     <= '0;
         txd      <= 1'b1;
      end else begin
         txd <= txd_nxt;
         if (pop) begin
            hold     <= fifo_dout;
            byte_idx <= '0;
         end
         if ((state == ST_IDLE) || bit_done) baud_cnt <= '0;
         else                                baud_cnt <= baud_cnt + 1'b1;
         if ((state == ST_DATA) && bit_done) bit_idx  <= bit_idx + 1'b1;
         if ((state == ST_STOP) && bit_done) byte_idx <= byte_idx + 1'b1;
      end
   end

endmodule

// File: tb/tb_fir_sample_uart_tx.sv
// Bench for fir_sample_uart_tx: two instances (DECIM=1/SHIFT=16 and DECIM=4/SHIFT=0), UART line decoder,
// expected samples from a plain-arithmetic model of decimation, shift and clamp.
module tb_fir_sample_uart_tx;

   localparam int C = 4;

   logic               clk = 1'b0;
   logic               reset = 1'b1;
   logic signed [47:0] in_val = '0;
   logic               rdy_a = 1'b0;
   logic               rdy_b = 1'b0;
   logic               txd_a, busy_a, ovf_a;
   logic               txd_b, busy_b, ovf_b;

   always #5 clk = ~clk;

   fir_sample_uart_tx #(.CLKS_PER_BIT(C), .SHIFT(16), .DECIM(1), .FIFO_AW(3)) dut_a (
      .clk(clk), .reset(reset), .in_val(in_val), .in_ready(rdy_a),
      .txd(txd_a), .busy(busy_a), .overflow(ovf_a));

   fir_sample_uart_tx #(.CLKS_PER_BIT(C), .SHIFT(0), .DECIM(4), .FIFO_AW(3)) dut_b (
      .clk(clk), .reset(reset), .in_val(in_val), .in_ready(rdy_b),
      .txd(txd_b), .busy(busy_b), .overflow(ovf_b));

   int n_chk = 0;
   int n_pass = 0;
   int cyc = 0;
   bit sel_b = 1'b0;
   int nb = 0;
   bit watch_ovf = 1'b0;
   bit ovf_low_seen = 1'b0;

   typedef struct {
      logic [7:0] b;
      int         st;
      bit         ok;
   } rx_t;

   rx_t         rx_q[$];
   logic [15:0] exp_q[$];
   int          st_q[$];

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // UART line decoder: one entry per byte with its start-bit cycle and a framing/width flag.
   initial begin : rx_mon
      int         rx_cnt;
      int         rx_st;
      logic [9:0] rx_bits;
      bit         rx_bad;
      logic       line;
      rx_cnt = -1;
      rx_st = 0;
      rx_bits = '0;
      rx_bad = 1'b0;
      forever begin
         @(negedge clk);
         line = sel_b ? txd_b : txd_a;
         if (watch_ovf && ovf_a !== 1'b1) ovf_low_seen = 1'b1;
         if (reset) begin
            rx_cnt = -1;
         end else if (rx_cnt < 0) begin
            if (line === 1'b0) begin
               rx_cnt = 1;
               rx_st = cyc;
               rx_bits = '0;
               rx_bad = 1'b0;
            end
         end else begin
            if (rx_cnt % C == 0) rx_bits[rx_cnt / C] = line;
            else if (line !== rx_bits[rx_cnt / C]) rx_bad = 1'b1;
            if (rx_cnt == 10 * C - 1) begin
               rx_q.push_back('{b: rx_bits[8:1], st: rx_st,
                                ok: (!rx_bad && rx_bits[0] == 1'b0 && rx_bits[9] == 1'b1)});
               rx_cnt = -1;
            end else begin
               rx_cnt++;
            end
         end
      end
   end

   function automatic logic [15:0] model_sat(input logic signed [47:0] v, input int sh);
      longint s;
      s = longint'(v) >>> sh;
      if (s > 32767) return 16'h7FFF;
      if (s < -32768) return 16'h8000;
      return 16'(s);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic cycles(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // One-cycle strobe on the selected instance; the model queue gets every kept sample.
   task automatic strobe(input logic signed [47:0] v, output int k);
      k = cyc;
      in_val = v;
      if (sel_b) begin
         rdy_b = 1'b1;
         nb++;
         if (nb % 4 == 0) exp_q.push_back(model_sat(v, 0));
      end else begin
         rdy_a = 1'b1;
         exp_q.push_back(model_sat(v, 16));
      end
      cycles(1);
      rdy_a = 1'b0;
      rdy_b = 1'b0;
   endtask

   task automatic check_frames(input int n, input string tag);
      int          waited;
      rx_t         b0, b1, b2;
      logic [15:0] e;
      waited = 0;
      st_q.delete();
      while (rx_q.size() < 3 * n && waited < 4000) begin
         cycles(1);
         waited++;
      end
      cycles(130);
      chk({tag, "_bytes"}, rx_q.size(), 3 * n);
      for (int i = 0; i < n; i++) begin
         if (rx_q.size() < 3) break;
         b0 = rx_q.pop_front();
         b1 = rx_q.pop_front();
         b2 = rx_q.pop_front();
         e = 16'hxxxx;
         if (exp_q.size() > 0) e = exp_q.pop_front();
         chk({tag, "_sync"}, b0.b, 8'hA5);
         chk({tag, "_payload"}, {b1.b, b2.b}, e);
         chk({tag, "_framing"}, {b0.ok, b1.ok, b2.ok}, 3'b111);
         chk({tag, "_bytegap"}, b2.st - b0.st, 20 * C);
         st_q.push_back(b0.st);
      end
      chk({tag, "_model_left"}, exp_q.size(), 0);
   endtask

   initial begin : main
      int k, k2;
      int x;
      logic signed [47:0] r;

      // Reset state.
      cycles(3);
      chk("rst_txd_a", txd_a, 1'b1);
      chk("rst_busy_a", busy_a, 1'b0);
      chk("rst_ovf_a", ovf_a, 1'b0);
      chk("rst_txd_b", txd_b, 1'b1);
      chk("rst_busy_b", busy_b, 1'b0);
      reset = 1'b0;
      cycles(2);

      // Single strobe: bytes A5,12,34, start bit 4 cycles after strobe, busy for the frame.
      strobe(48'sh0000_1234_0000, k);
      cycles(1);
      chk("t1_busy_pre", busy_a, 1'b0);
      cycles(1);
      chk("t1_busy_rise", busy_a, 1'b1);
      cycles(119);
      chk("t1_busy_last", busy_a, 1'b1);
      cycles(1);
      chk("t1_busy_fall", busy_a, 1'b0);
      check_frames(1, "t1");
      if (st_q.size() > 0) chk("t1_start_lat", st_q[0] - k, 4);

      // Saturation corners.
      strobe(48'sh0001_0000_0000, k);
      cycles(3);
      strobe(48'shFFFF_0000_0000, k);
      cycles(3);
      strobe(48'shFFFF_FFFF_0000, k);
      check_frames(3, "t2");

      // Random values with random spacing (never more than the FIFO can absorb).
      for (int i = 0; i < 6; i++) begin
         r = {16'($urandom()), 32'($urandom())};
         r = r >>> $urandom_range(0, 32);
         strobe(r, k);
         cycles($urandom_range(1, 15));
      end
      check_frames(6, "rnd");

      // Ten back-to-back strobes: nine frames, tenth dropped, overflow sticky.
      for (int i = 0; i < 10; i++) begin
         if (i == 0) strobe(48'sd1000 <<< 16, k);
         else        strobe(48'(i * 4097) <<< 16, k2);
      end
      void'(exp_q.pop_back());
      chk("t4_ovf_before", ovf_a, 1'b0);
      cycles(1);
      chk("t4_ovf_set", ovf_a, 1'b1);
      watch_ovf = 1'b1;
      check_frames(9, "t4");
      watch_ovf = 1'b0;
      chk("t4_ovf_held", ovf_low_seen, 1'b0);
      chk("t4_ovf_end", ovf_a, 1'b1);

      // Reset during DATA bit 3 of byte 1 discards everything queued.
      strobe(48'sh0000_1111_0000, k);
      strobe(48'sh0000_2222_0000, k2);
      strobe(48'sh0000_3333_0000, k2);
      cycles(k + 61 - cyc);
      reset = 1'b1;
      cycles(1);
      reset = 1'b0;
      chk("t5_txd", txd_a, 1'b1);
      chk("t5_busy", busy_a, 1'b0);
      chk("t5_ovf", ovf_a, 1'b0);
      exp_q.delete();
      rx_q.delete();
      nb = 0;
      cycles(200);
      chk("t5_no_frames", rx_q.size(), 0);
      chk("t5_idle", busy_a, 1'b0);
      strobe(48'sh0000_ABCD_0000, k);
      check_frames(1, "t5_after");

      // Strobe during a frame: second frame follows after exactly one idle cycle.
      strobe(48'sh0000_0102_0000, k);
      cycles(60);
      strobe(-48'sd1234567, k2);
      check_frames(2, "t6");
      if (st_q.size() == 2) chk("t6_gap", st_q[1] - st_q[0], 30 * C + 1);

      // DECIM=4, SHIFT=0: eight strobes give two frames carrying strobes 4 and 8.
      sel_b = 1'b1;
      cycles(2);
      for (int i = 1; i <= 8; i++) begin
         if (i == 4) begin
            r = 48'sd5;
         end else if (i == 8) begin
            r = {16'($urandom()), 32'($urandom())};
         end else begin
            x = int'($urandom_range(0, 65535)) - 32768;
            r = x;
         end
         strobe(r, k);
         cycles($urandom_range(0, 4));
      end
      check_frames(2, "t3");
      chk("t3_ovf", ovf_b, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
